// File: rtl/ch_fifo_wr_arbiter.sv
// ch_fifo_wr_arbiter
//   Four-channel write-side scheduler in front of the shared acquisition
//   DCFIFO. Each channel's sparse sample strobes are buffered in a small
//   holding queue. The queues are round-robin arbitrated onto the single
//   DCFIFO write port. Every word is tagged with its channel ID and a
//   per-channel sequence number, so the reader can detect dropped samples
//   from gaps in the sequence. Everything runs on ch_wrclk; the DCFIFO
//   itself performs the crossing to the read clock.
//
// Ports
//   ch_wrclk    in   write-domain clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   1 = accept samples, 0 = stop accepting, drain, go idle
//   ch_wrreq    in   [3:0] per-channel sample strobe
//   ch_data     in   [4*DW-1:0] channel i data at [i*DW +: DW]
//   fifo_full   in   DCFIFO wrfull / almost-full, blocks grants
//   clr_stat    in   clears ovf_flag and drop_cnt
//   fifo_wrreq  out  DCFIFO write strobe
//   fifo_data   out  [DW+7:0] {ch_id[1:0], seq[5:0], data[DW-1:0]}
//   ovf_flag    out  [3:0] sticky per-channel overflow
//   drop_cnt    out  [CNT_W-1:0] saturating count of dropped samples
//   busy        out  high while in RUN or DRAIN

module ch_fifo_wr_arbiter #(
  parameter int DW         = 32,
  parameter int HOLD_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              ch_wrclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [3:0]        ch_wrreq,
  input  logic [4*DW-1:0]   ch_data,
  input  logic              fifo_full,
  input  logic              clr_stat,
  output logic              fifo_wrreq,
  output logic [DW+7:0]     fifo_data,
  output logic [3:0]        ovf_flag,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
);

  // Queue pointers wrap naturally because HOLD_DEPTH is a power of two.
  // The occupancy counter needs one extra bit to represent "full".
  localparam int AW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int EW = DW + 6;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(HOLD_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  // Holding queues: each entry is {seq, data}; channel ID is implied by
  // the queue index and is added when the word is sent.
  logic [3:0][HOLD_DEPTH-1:0][EW-1:0] q_mem;
  logic [3:0][AW-1:0]                 q_wr_ptr;
  logic [3:0][AW-1:0]                 q_rd_ptr;
  logic [3:0][AW:0]                   q_cnt;
  logic [3:0][5:0]                    seq;
  logic [1:0]                         rr;

  logic [3:0]       q_nonempty;
  logic [3:0]       q_pop;
  logic [3:0]       push_try;
  logic [3:0]       push_ok;
  logic [3:0]       push_drop;
  logic             grant_vld;
  logic [1:0]       grant_id;
  logic [1:0]       cand;
  logic [EW-1:0]    head_entry;
  logic [2:0]       drop_num;
  logic [CNT_W-1:0] drop_base;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_cnt_nxt;
  logic [3:0]       ovf_nxt;

  // State register.
  always_ff @(posedge ch_wrclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. DRAIN keeps granting until every queue is empty;
  // re-enabling while draining goes straight back to RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!en) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (en)                state_nxt = ST_RUN;
        else if (~|q_nonempty) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Round-robin grant: search from rr+1 upward, wrapping 3->0, so the
  // channel served last has lowest priority next time. No grant while the
  // DCFIFO reports full or while idle.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = rr;
    cand      = rr;
    for (int k = 1; k <= 4; k++) begin
      cand = rr + 2'(k);
      if (!grant_vld && q_nonempty[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    if (state == ST_IDLE || fifo_full) begin
      grant_vld = 1'b0;
    end
  end

  // Per-channel push/pop decisions. A full queue that is being popped in
  // the same cycle still has room, so the push is accepted.
  always_comb begin
    q_nonempty = '0;
    q_pop      = '0;
    push_try   = '0;
    push_ok    = '0;
    push_drop  = '0;
    for (int i = 0; i < 4; i++) begin
      q_nonempty[i] = (q_cnt[i] != '0);
      q_pop[i]      = grant_vld && (grant_id == 2'(i));
      push_try[i]   = (state == ST_RUN) && ch_wrreq[i];
      push_ok[i]    = push_try[i] && ((q_cnt[i] != CNT_FULL) || q_pop[i]);
      push_drop[i]  = push_try[i] && !push_ok[i];
    end
  end

  assign head_entry = q_mem[grant_id][q_rd_ptr[grant_id]];

  // Queue bookkeeping and sequence counters. The sequence advances on
  // every attempted push, accepted or not, so drops leave visible gaps.
  always_ff @(posedge ch_wrclk or negedge rst_n) begin
    if (!rst_n) begin
      q_wr_ptr <= '0;
      q_rd_ptr <= '0;
      q_cnt    <= '0;
      seq      <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_try[i]) seq[i] <= seq[i] + 6'd1;
        if (push_ok[i])  q_wr_ptr[i] <= q_wr_ptr[i] + 1'b1;
        if (q_pop[i])    q_rd_ptr[i] <= q_rd_ptr[i] + 1'b1;
        case ({push_ok[i], q_pop[i]})
          2'b10:   q_cnt[i] <= q_cnt[i] + 1'b1;
          2'b01:   q_cnt[i] <= q_cnt[i] - 1'b1;
          default: q_cnt[i] <= q_cnt[i];
        endcase
      end
    end
  end

  // Queue storage. Contents need no reset: flushing the pointers and
  // counts on reset is enough to discard buffered samples.
  always_ff @(posedge ch_wrclk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_ok[i]) begin
        q_mem[i][q_wr_ptr[i]] <= {seq[i], ch_data[i*DW +: DW]};
      end
    end
  end

  // DCFIFO write port. fifo_data holds its last value between writes.
  always_ff @(posedge ch_wrclk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      rr         <= 2'd3;
    end else begin
      fifo_wrreq <= grant_vld;
      if (grant_vld) begin
        fifo_data <= {grant_id, head_entry};
        rr        <= grant_id;
      end
    end
  end

  // Drop statistics. A clear and a drop in the same cycle: the clear
  // wipes the old totals, then this cycle's drops are applied on top.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < 4; i++) begin
      drop_num = drop_num + {2'b00, push_drop[i]};
    end
    drop_base    = clr_stat ? '0 : drop_cnt;
    drop_sum     = {1'b0, drop_base} + (CNT_W + 1)'(drop_num);
    drop_cnt_nxt = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    ovf_nxt      = (clr_stat ? 4'b0000 : ovf_flag) | push_drop;
  end

  always_ff @(posedge ch_wrclk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= '0;
      drop_cnt <= '0;
    end else begin
      ovf_flag <= ovf_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

endmodule
